maze_mem: RTL and testbench
===========================

# maze_mem

Maze storage for the wall-follower solver. It loads a 2^maze_width × 2^maze_width wall bitmap from a serial valid/ready stream, then serves the solver's `row`/`col`/`maze_oe`/`maze_we` accesses with registered read data on `maze_in` and records visited cells. When the solver raises `done`, it streams the marked maze out for checking or display.

## Interface
- `maze_width`, default 6: bits per coordinate; the maze is N×N with N = 2^maze_width cells.
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  reset: one clock; synchronous, active-high.
- `load_valid`  in  1  load stream data valid.
- `load_data`  in  1  cell wall bit (1 = wall, 0 = free).
- `load_ready`  out  1  block accepts a load beat.
- `load_done`  out  1  sticky; the full maze has been loaded.
- `row`, `col`  in  maze_width  solver cell address.
- `maze_oe`  in  1  solver read request.
- `maze_we`  in  1  solver mark-visited request.
- `maze_in`  out  1  wall bit of the last cell read.
- `done`  in  1  solver found the exit.
- `dump_valid`  out  1  dump beat valid.
- `dump_data`  out  2  {path, wall} of the current cell.
- `dump_ready`  in  1  dump consumer accepts the beat.
- `dump_done`  out  1  sticky; all cells have been dumped.

## Operation
- Storage:
  - `wall[N*N]` and `path[N*N]` bit arrays.
  - Cell address = {row, col}, row-major with col fastest.
  - 2·maze_width-bit counter `cnt`.
- FSM states: LOAD → SOLVE → DUMP → FINISH. FINISH holds until `rst`.
- LOAD:
  - `load_ready` = 1.
  - On each beat (`load_valid & load_ready`): `wall[cnt]` ← `load_data`, `path[cnt]` ← 0, `cnt` ← `cnt` + 1.
  - Loading clears the path array, so reset never clears the arrays themselves.
  - The beat at `cnt` = N*N−1 sets `load_done`, wraps `cnt` to 0, and moves to SOLVE.
- SOLVE:
  - When `maze_oe` = 1: `maze_in` ← `wall[{row,col}]` at the edge.
  - When `maze_oe` = 0: `maze_in` holds its value.
  - When `maze_we` = 1: `path[{row,col}]` ← 1. Walls are never modified.
  - `maze_oe` and `maze_we` in the same cycle at the same cell: both actions take place, and `maze_in` returns the wall bit.
  - `done` = 1 sampled at an edge moves to DUMP. Accesses in that same cycle are still performed.
- DUMP:
  - `dump_data` = {path[cnt], wall[cnt]}, held stable while `dump_valid & !dump_ready`.
  - Each beat (`dump_valid & dump_ready`) advances `cnt` and loads the next cell.
  - The beat at `cnt` = N*N−1 deasserts `dump_valid`, sets `dump_done`, and moves to FINISH.
- Outside SOLVE, `maze_oe`, `maze_we` and `done` are ignored. Outside LOAD, `load_valid` is ignored and `load_ready` = 0.

## Timing
- Reset values, after any edge with `rst` = 1:
  - state = LOAD, `cnt` = 0
  - `maze_in` = 1, `dump_valid` = 0, `dump_data` = 0
  - `load_done` = 0, `dump_done` = 0
  - `load_ready` = 1 from the first cycle after reset
- `rst` takes priority over every other input in the same cycle.
- Reset mid-operation (LOAD, SOLVE or DUMP) aborts immediately. Partial array contents are don't-care, because the next full load rewrites them.
- `load_ready` is a combinational decode of the state. A load takes exactly N*N accepted beats; at `load_valid` = 1 continuously, that is N*N cycles.
- Read latency is 1 cycle. `maze_oe` applied during cycle t gives `maze_in` valid in cycle t+1, which matches the solver's read-then-next-state pattern.
- Write takes effect at the edge. A read of the same cell in the following cycle sees the updated path; the wall value is unchanged.
- `dump_valid` first rises 1 cycle after entering DUMP. With `dump_ready` held at 1, there is one beat per cycle and the dump takes N*N cycles.
- `load_done` and `dump_done` stay at 1 until `rst`.

## Test plan
All scenarios use maze_width = 2 (4×4 maze, 16 cells).
- **Load with stalls.** Stream 16 bits of pattern 0xF99F (row 0 first, MSB = cell 0) with `load_valid` deasserted every other cycle. Required: exactly 16 beats accepted, `load_done` = 1 and `load_ready` = 0 after the 16th, and extra `load_valid` ignored.
- **Read latency.** After loading, drive `maze_oe` = 1 with {row,col} = {1,1}, then {0,1}. Required: `maze_in` = 0 one cycle later, then 1. With `maze_oe` = 0, `maze_in` holds 1.
- **Write and read in the same cycle.** Drive `maze_we` = `maze_oe` = 1 at {2,2}. Required: `maze_in` = 0, and the dump later shows cell 10 as 2'b10.
- **Dump with back-pressure.** Mark {1,1} and {1,2}, then pulse `done`. Hold `dump_ready` low for 3 cycles after `dump_valid` rises. Required:
  - `dump_data` stable at 2'b01 throughout the stall.
  - The 16 beats come out in row-major order, with cells 5 and 6 = 2'b10.
  - `dump_done` = 1 after the last beat.
- **Reset mid-solve.** Assert `rst` in SOLVE after marks have been made. Required: `maze_in` = 1 and `load_ready` = 1 next cycle. After reloading 0xF99F and going straight to `done`, the dump shows no path bits.
- **Reset mid-load.** Assert `rst` during LOAD, after 7 accepted beats. Required: `cnt` restarts at 0, and exactly 16 new beats are needed to set `load_done`.

Source files
------------

// File: rtl/maze_mem_if.sv
// Maze storage bus: load stream, solver access port and dump stream.
// The slave side is the maze store; the master side is the environment.
interface maze_mem_if #(
  parameter int maze_width = 6
);
  logic                  load_valid;
  logic                  load_data;
  logic                  load_ready;
  logic                  load_done;
  logic [maze_width-1:0] row;
  logic [maze_width-1:0] col;
  logic                  maze_oe;
  logic                  maze_we;
  logic                  maze_in;
  logic                  done;
  logic                  dump_valid;
  logic [1:0]            dump_data;
  logic                  dump_ready;
  logic                  dump_done;

  modport slave (
    input  load_valid, load_data,
    input  row, col, maze_oe, maze_we, done,
    input  dump_ready,
    output load_ready, load_done, maze_in,
    output dump_valid, dump_data, dump_done
  );

  modport master (
    output load_valid, load_data,
    output row, col, maze_oe, maze_we, done,
    output dump_ready,
    input  load_ready, load_done, maze_in,
    input  dump_valid, dump_data, dump_done
  );
endinterface

// File: rtl/maze_mem.sv
// Wall/path bitmap store for the wall-follower solver.
// Loads walls serially, serves solver reads/marks, then dumps {path,wall}.
module maze_mem #(
  parameter int maze_width = 6
) (
  input  logic      clk,
  input  logic      rst,
  maze_mem_if.slave bus
);
  localparam int aw    = 2 * maze_width;
  localparam int cells = 1 << aw;

  localparam logic [1:0] LOAD   = 2'd0;
  localparam logic [1:0] SOLVE  = 2'd1;
  localparam logic [1:0] DUMP   = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  logic [1:0]       state;
  logic [aw-1:0]    cnt;
  logic [aw-1:0]    nxt;
  logic [aw-1:0]    addr;
  logic [cells-1:0] wall;
  logic [cells-1:0] path;
  logic             last;
  logic             load_beat;
  logic             dump_beat;

  assign addr      = {bus.row, bus.col};
  assign nxt       = cnt + 1'b1;
  assign last      = (cnt == {aw{1'b1}});
  assign load_beat = bus.load_valid & bus.load_ready;
  assign dump_beat = bus.dump_valid & bus.dump_ready;

  assign bus.load_ready = (state == LOAD);

  // Arrays carry no reset; a full load rewrites every cell.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (load_beat) begin
        wall[cnt] <= bus.load_data;
        path[cnt] <= 1'b0;
      end else if (state == SOLVE && bus.maze_we) begin
        path[addr] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= LOAD;
      cnt            <= '0;
      bus.maze_in    <= 1'b1;
      bus.dump_valid <= 1'b0;
      bus.dump_data  <= 2'b00;
      bus.load_done  <= 1'b0;
      bus.dump_done  <= 1'b0;
    end else begin
      unique case (1'b1)
        state == LOAD: begin
          if (load_beat) begin
            cnt <= nxt;
            if (last) begin
              bus.load_done <= 1'b1;
              state         <= SOLVE;
            end
          end
        end
        state == SOLVE: begin
          if (bus.maze_oe) bus.maze_in <= wall[addr];
          if (bus.done) state <= DUMP;
        end
        state == DUMP: begin
          // First DUMP cycle primes cell 0 after the final solver write.
          if (!bus.dump_valid) begin
            bus.dump_valid <= 1'b1;
            bus.dump_data  <= {path[cnt], wall[cnt]};
          end else if (dump_beat) begin
            if (last) begin
              bus.dump_valid <= 1'b0;
              bus.dump_done  <= 1'b1;
              state          <= FINISH;
            end else begin
              cnt           <= nxt;
              bus.dump_data <= {path[nxt], wall[nxt]};
            end
          end
        end
        state == FINISH: ;
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_maze_mem.sv
// Directed bench for maze_mem on a 4x4 maze.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_maze_mem;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  maze_mem_if #(.maze_width(2)) bus ();

  maze_mem #(.maze_width(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] pat  = 16'hF99F;
  localparam logic [15:0] pat2 = 16'hA5C3;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic load_all(input logic [15:0] p);
    for (int i = 0; i < 16; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = p[15-i];
      step();
    end
    bus.load_valid = 1'b0;
  endtask

  // Expects dump_valid already up; checks 16 beats against wall/path masks.
  task automatic dump_run(input logic [15:0] p, input logic [15:0] pm);
    int n;
    logic [1:0] e;
    n = 0;
    bus.dump_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && n < 16; cyc++) begin
      if (bus.dump_valid) begin
        e = {pm[15-n], p[15-n]};
        chk($sformatf("cell%0d", n), 16'(bus.dump_data), 16'(e));
        n++;
      end
      step();
    end
    chk("dump_beats", 16'(n), 16'd16);
    chk("dump_done", 16'(bus.dump_done), 16'd1);
    chk("dump_valid_end", 16'(bus.dump_valid), 16'd0);
    bus.dump_ready = 1'b0;
  endtask

  initial begin
    int acc;
    rst            = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = 1'b0;
    bus.row        = '0;
    bus.col        = '0;
    bus.maze_oe    = 1'b0;
    bus.maze_we    = 1'b0;
    bus.done       = 1'b0;
    bus.dump_ready = 1'b0;
    #2;
    do_reset();

    chk("rst_maze_in", 16'(bus.maze_in), 16'd1);
    chk("rst_dump_valid", 16'(bus.dump_valid), 16'd0);
    chk("rst_dump_data", 16'(bus.dump_data), 16'd0);
    chk("rst_load_done", 16'(bus.load_done), 16'd0);
    chk("rst_dump_done", 16'(bus.dump_done), 16'd0);
    chk("rst_load_ready", 16'(bus.load_ready), 16'd1);

    // Load with a bubble every other cycle.
    acc = 0;
    for (int i = 0; i < 32; i++) begin
      bus.load_valid = (i % 2 == 0);
      bus.load_data  = pat[15-i/2];
      if (bus.load_valid && bus.load_ready) acc++;
      step();
      if (i == 28) chk("load_done_early", 16'(bus.load_done), 16'd0);
    end
    chk("load_beats", 16'(acc), 16'd16);
    chk("load_done", 16'(bus.load_done), 16'd1);
    chk("load_ready_solve", 16'(bus.load_ready), 16'd0);
    for (int i = 0; i < 3; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 1'b0;
      step();
    end
    bus.load_valid = 1'b0;
    chk("load_ready_extra", 16'(bus.load_ready), 16'd0);

    // Read latency and hold.
    bus.maze_oe = 1'b1; bus.row = 2'd1; bus.col = 2'd1;
    step();
    chk("rd_1_1", 16'(bus.maze_in), 16'd0);
    bus.row = 2'd0; bus.col = 2'd1;
    step();
    chk("rd_0_1", 16'(bus.maze_in), 16'd1);
    bus.maze_oe = 1'b0; bus.row = 2'd1; bus.col = 2'd1;
    step();
    chk("rd_hold", 16'(bus.maze_in), 16'd1);

    // Same-cycle write and read.
    bus.maze_oe = 1'b1; bus.maze_we = 1'b1;
    bus.row = 2'd2; bus.col = 2'd2;
    step();
    chk("rw_2_2", 16'(bus.maze_in), 16'd0);
    bus.maze_we = 1'b0; bus.row = 2'd0; bus.col = 2'd0;
    step();
    chk("rd_0_0", 16'(bus.maze_in), 16'd1);
    bus.maze_oe = 1'b0;

    // Marks, then done with back-pressure on the dump.
    bus.maze_we = 1'b1; bus.row = 2'd1; bus.col = 2'd1;
    step();
    bus.col = 2'd2;
    step();
    bus.maze_we = 1'b0;
    bus.done    = 1'b1;
    step();
    bus.done = 1'b0;
    chk("dump_valid_entry", 16'(bus.dump_valid), 16'd0);
    step();
    chk("dump_valid_rise", 16'(bus.dump_valid), 16'd1);
    chk("stall_data0", 16'(bus.dump_data), 16'b01);
    for (int k = 1; k < 3; k++) begin
      step();
      chk($sformatf("stall_data%0d", k), 16'(bus.dump_data), 16'b01);
      chk($sformatf("stall_valid%0d", k), 16'(bus.dump_valid), 16'd1);
    end
    dump_run(pat, 16'h0620);

    // Reset mid-solve.
    do_reset();
    load_all(pat);
    bus.maze_we = 1'b1; bus.row = 2'd0; bus.col = 2'd0;
    step();
    bus.row = 2'd3; bus.col = 2'd3;
    step();
    bus.maze_we = 1'b0; bus.maze_oe = 1'b1; bus.row = 2'd1; bus.col = 2'd1;
    step();
    bus.maze_oe = 1'b0;
    chk("pre_rst_maze_in", 16'(bus.maze_in), 16'd0);
    do_reset();
    chk("mid_rst_maze_in", 16'(bus.maze_in), 16'd1);
    chk("mid_rst_load_ready", 16'(bus.load_ready), 16'd1);
    load_all(pat);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    step();
    dump_run(pat, 16'h0000);

    // Reset mid-load after 7 beats.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 1'b1;
      step();
    end
    bus.load_valid = 1'b0;
    do_reset();
    chk("ml_load_ready", 16'(bus.load_ready), 16'd1);
    chk("ml_load_done", 16'(bus.load_done), 16'd0);
    for (int i = 0; i < 16; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = pat2[15-i];
      step();
      if (i == 14) chk("ml_done_15", 16'(bus.load_done), 16'd0);
    end
    bus.load_valid = 1'b0;
    chk("ml_done_16", 16'(bus.load_done), 16'd1);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    step();
    dump_run(pat2, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
